// File: rtl/count_run_ctrl.sv
// Run/pause/done controller for a 4-digit BCD counter: synchronizes the operator
// buttons, divides the clock down to count ticks and stops at the terminal count.
module count_run_ctrl #(
    parameter int unsigned TICK_DIV = 50000000,
    parameter logic [3:0]  TC3      = 4'd9,
    parameter logic [3:0]  TC2      = 4'd6,
    parameter logic [3:0]  TC1      = 4'd7,
    parameter logic [3:0]  TC0      = 4'd5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_btn,
    input  logic       stop_btn,
    input  logic       clr_btn,
    input  logic [3:0] Qdata3,
    input  logic [3:0] Qdata2,
    input  logic [3:0] Qdata1,
    input  logic [3:0] Qdata0,
    output logic       cnt_tick,
    output logic       cnt_clr,
    output logic [1:0] state,
    output logic       running,
    output logic       done
);

    localparam int unsigned    PW       = $clog2(TICK_DIV);
    localparam logic [PW-1:0]  PRE_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        st, st_nx;
    logic [PW-1:0] pre, pre_nx;
    logic          clr_nx;

    // Button vectors are packed as {clr, stop, start}.
    logic [2:0] btn_p0, btn_p1, btn_p2, armed;
    logic       vld_p0, vld_p1;
    logic [2:0] ev;
    logic       ev_start, ev_stop, ev_clr;
    logic       at_tc;

    // Stage 0/1 synchronize, stage 2 remembers the previous level for edge detection.
    // A button is only armed once a genuine post-reset low has been seen, so a
    // button held through reset release cannot fire.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_p0 <= '0;
            btn_p1 <= '0;
            btn_p2 <= '0;
            armed  <= '0;
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            btn_p0 <= {clr_btn, stop_btn, start_btn};
            btn_p1 <= btn_p0;
            btn_p2 <= btn_p1;
            armed  <= armed | ({3{vld_p1}} & ~btn_p1);
            vld_p0 <= 1'b1;
            vld_p1 <= vld_p0;
        end
    end

    assign ev       = btn_p1 & ~btn_p2 & armed;
    assign ev_start = ev[0];
    assign ev_stop  = ev[1];
    assign ev_clr   = ev[2];
    assign at_tc    = ({Qdata3, Qdata2, Qdata1, Qdata0} == {TC3, TC2, TC1, TC0});

    always_ff @(posedge clk) begin
        if (rst) begin
            st      <= S_IDLE;
            pre     <= '0;
            cnt_clr <= 1'b1;
        end else begin
            st      <= st_nx;
            pre     <= pre_nx;
            cnt_clr <= clr_nx;
        end
    end

    always_comb begin
        st_nx  = st;
        pre_nx = pre;
        clr_nx = 1'b0;
        if (ev_clr) begin
            st_nx  = S_IDLE;
            pre_nx = '0;
            clr_nx = 1'b1;
        end else begin
            case (st)
                S_IDLE: begin
                    if (!ev_stop && ev_start) begin
                        st_nx  = S_RUN;
                        pre_nx = '0;
                    end
                end
                S_RUN: begin
                    if (ev_stop) begin
                        st_nx = S_PAUSE;
                    end else if (pre == PRE_LAST) begin
                        pre_nx = '0;
                        if (at_tc) st_nx = S_DONE;
                    end else begin
                        pre_nx = pre + PW'(1);
                    end
                end
                S_PAUSE: begin
                    if (!ev_stop && ev_start) st_nx = S_RUN;
                end
                S_DONE: begin
                    // Stop is ignored here; a start restarts the count from zero.
                    if (ev_start) begin
                        st_nx  = S_RUN;
                        pre_nx = '0;
                        clr_nx = 1'b1;
                    end
                end
                default: begin
                    st_nx  = S_IDLE;
                    pre_nx = '0;
                end
            endcase
        end
    end

    always_comb begin
        state    = st;
        running  = !rst && (st == S_RUN);
        done     = !rst && (st == S_DONE);
        cnt_tick = !rst && (st == S_RUN) && (pre == PRE_LAST)
                   && !ev_stop && !ev_clr && !at_tc;
    end

endmodule
